// File: rtl/iir_channel_scheduler_pkg.sv
// Shared sizing, FSM encoding and round-robin helper for the multi-channel
// first-order IIR scheduler.
package iir_channel_scheduler_pkg;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int CHW = $clog2(NCH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CALC  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // First requesting channel strictly after 'last', wrapping; returns 'last' when none request.
    function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] valid,
                                               input logic [CHW-1:0] last);
        logic [CHW-1:0] pick;
        logic [CHW-1:0] idx;
        logic           found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CHW'((int'(last) + k) % NCH);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/iir_channel_scheduler_mac.sv
// Shared first-order IIR datapath: y = x + a*y_prev modulo 2^W, registered
// while the scheduler is in CALC.
module iir_mac_engine #(
    parameter int W = iir_channel_scheduler_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] a,
    input  logic [W-1:0] y_prev,
    output logic [W-1:0] y
);

    logic [2*W-1:0] prod_s;
    logic [W-1:0]   sum_s;
    logic [W-1:0]   y_r;

    // Full-width product; only the low W bits survive the modular sum.
    always_comb begin
        prod_s = {{W{1'b0}}, a} * {{W{1'b0}}, y_prev};
        sum_s  = x + prod_s[W-1:0];
    end

    // Result register, held between calculations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_r <= {W{1'b0}};
        end else if (en) begin
            y_r <= sum_s;
        end else begin
            y_r <= y_r;
        end
    end

    assign y = y_r;

endmodule

// File: rtl/iir_channel_scheduler.sv
// Round-robin scheduler time-sharing one IIR engine across NCH channels,
// each with its own coefficient and feedback state.
module iir_channel_scheduler #(
    parameter int NCH = iir_channel_scheduler_pkg::NCH,
    parameter int W   = iir_channel_scheduler_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH*W-1:0] req_x,
    output logic [NCH-1:0]   req_ready,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [W-1:0]     cfg_a,
    output logic             out_valid,
    output logic [1:0]       out_ch,
    output logic [W-1:0]     out_y,
    output logic             busy
);

    import iir_channel_scheduler_pkg::*;

    state_t          state_r;
    logic [CHW-1:0]  grant_ch_r;
    logic [CHW-1:0]  last_r;
    logic [NCH-1:0]  req_ready_r;
    logic            out_valid_r;
    logic [CHW-1:0]  out_ch_r;
    logic            busy_r;
    logic [W-1:0]    x_op_r;
    logic [W-1:0]    a_op_r;
    logic [W-1:0]    yp_op_r;
    logic [W-1:0]    a_r      [NCH];
    logic [W-1:0]    y_prev_r [NCH];

    logic            any_valid_s;
    logic [CHW-1:0]  pick_s;
    logic            calc_en_s;
    logic [W-1:0]    mac_y_s;

    // Arbitration is resolved one cycle ahead so req_ready can be a register.
    always_comb begin
        any_valid_s = |req_valid;
        pick_s      = rr_pick(req_valid, last_r);
        calc_en_s   = (state_r == ST_CALC);
    end

    // Scheduler FSM with registered handshake and result-strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            grant_ch_r  <= {CHW{1'b0}};
            last_r      <= CHW'(NCH - 1);
            req_ready_r <= {NCH{1'b0}};
            out_valid_r <= 1'b0;
            out_ch_r    <= {CHW{1'b0}};
            busy_r      <= 1'b0;
            x_op_r      <= {W{1'b0}};
            a_op_r      <= {W{1'b0}};
            yp_op_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_EMIT: begin
                    out_valid_r <= 1'b0;
                    if (any_valid_s) begin
                        state_r     <= ST_GRANT;
                        grant_ch_r  <= pick_s;
                        last_r      <= pick_s;
                        req_ready_r <= {{(NCH-1){1'b0}}, 1'b1} << pick_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= {NCH{1'b0}};
                        busy_r      <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Operands are frozen here; later cfg writes cannot disturb this sample.
                    state_r     <= ST_CALC;
                    req_ready_r <= {NCH{1'b0}};
                    x_op_r      <= req_x[int'(grant_ch_r)*W +: W];
                    a_op_r      <= a_r[grant_ch_r];
                    yp_op_r     <= y_prev_r[grant_ch_r];
                    busy_r      <= 1'b1;
                end
                ST_CALC: begin
                    state_r     <= ST_EMIT;
                    out_valid_r <= 1'b1;
                    out_ch_r    <= grant_ch_r;
                    busy_r      <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= {NCH{1'b0}};
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel register file; a cfg write outranks the EMIT feedback update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                a_r[i]      <= {W{1'b0}};
                y_prev_r[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_ch == CHW'(i))) begin
                    a_r[i]      <= cfg_a;
                    y_prev_r[i] <= {W{1'b0}};
                end else if ((state_r == ST_EMIT) && (out_ch_r == CHW'(i))) begin
                    a_r[i]      <= a_r[i];
                    y_prev_r[i] <= mac_y_s;
                end else begin
                    a_r[i]      <= a_r[i];
                    y_prev_r[i] <= y_prev_r[i];
                end
            end
        end
    end

    iir_mac_engine #(
        .W(W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en     (calc_en_s),
        .x      (x_op_r),
        .a      (a_op_r),
        .y_prev (yp_op_r),
        .y      (mac_y_s)
    );

    assign req_ready = req_ready_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_y     = mac_y_s;
    assign busy      = busy_r;

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Directed self-checking bench for the IIR channel scheduler.
module tb_iir_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_x;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [3:0]  cfg_a;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [3:0]  out_y;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iir_channel_scheduler #(.NCH(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_a     (cfg_a),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_y     (out_y),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [3:0] a);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_a  = a;
        step();
        cfg_we = 1'b0;
    endtask

    // One request from IDLE through grant, result and return to IDLE.
    task automatic do_sample(input logic [1:0] ch, input logic [3:0] x, input logic [3:0] exp_y,
                             input logic emit_cfg, input logic [3:0] emit_a);
        int waited;
        req_x[int'(ch)*4 +: 4] = x;
        req_valid[ch] = 1'b1;
        step();
        waited = 1;
        while (req_ready == 4'b0000 && waited < 8) begin
            step();
            waited++;
        end
        chk("ready_onehot", req_ready, 4'b0001 << ch);
        chk("ready_wait", waited, 1);
        chk("busy_grant", busy, 1);
        req_valid[ch] = 1'b0;
        step();
        chk("calc_no_valid", out_valid, 0);
        chk("calc_ready_low", req_ready, 0);
        step();
        chk("emit_valid", out_valid, 1);
        chk("emit_ch", out_ch, ch);
        chk("emit_y", out_y, exp_y);
        if (emit_cfg) begin
            cfg_we = 1'b1;
            cfg_ch = ch;
            cfg_a  = emit_a;
        end
        step();
        cfg_we = 1'b0;
        chk("idle_valid", out_valid, 0);
        chk("hold_y", out_y, exp_y);
        chk("hold_ch", out_ch, ch);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int g;
        int o;
        int last_c;
        int idx;
        int exp_g [5];
        int exp_y [5];
        exp_g = '{0, 1, 2, 3, 0};
        exp_y = '{7, 4, 1, 1, 15};

        rst = 1'b0; req_valid = 4'b0000; req_x = 16'h0000;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_a = 4'd0;
        step(); step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        step();

        // ch0 a=2: 1, then 1+2*1=3
        cfg(2'd0, 4'd2);
        do_sample(2'd0, 4'd1, 4'd1, 1'b0, 4'd0);
        do_sample(2'd0, 4'd1, 4'd3, 1'b0, 4'd0);

        // ch1 a=3: 5, then 2+3*5=17 mod 16 = 1
        cfg(2'd1, 4'd3);
        do_sample(2'd1, 4'd5, 4'd5, 1'b0, 4'd0);
        do_sample(2'd1, 4'd2, 4'd1, 1'b0, 4'd0);

        // last grant ch1, only ch3 requesting: granted immediately
        do_sample(2'd3, 4'd7, 4'd7, 1'b0, 4'd0);

        // all channels requesting continuously
        req_x = 16'h1111;
        req_valid = 4'b1111;
        g = 0; o = 0; last_c = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (req_ready != 4'b0000) begin
                chk("stream_onehot", $onehot(req_ready), 1);
                idx = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
                if (g < 5) begin
                    chk("stream_order", idx, exp_g[g]);
                    if (g > 0) chk("stream_spacing", c - last_c, 3);
                end
                last_c = c;
                g++;
                if (g == 5) req_valid = 4'b0000;
            end
            if (out_valid) begin
                if (o < 5) begin
                    chk("stream_out_ch", out_ch, exp_g[o]);
                    chk("stream_out_y", out_y, exp_y[o]);
                end
                o++;
            end
        end
        chk("stream_grants", g, 5);
        chk("stream_outs", o, 5);

        // cfg to ch2 during its EMIT: output unchanged, feedback cleared, a=6
        do_sample(2'd2, 4'd3, 4'd3, 1'b1, 4'd6);
        do_sample(2'd2, 4'd4, 4'd4, 1'b0, 4'd0);

        // reset during CALC abandons the sample
        req_x[7:4] = 4'd9;
        req_valid[1] = 1'b1;
        step();
        chk("pre_rst_ready", req_ready, 4'b0010);
        req_valid[1] = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_y", out_y, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        chk("mid_rst_valid2", out_valid, 0);
        rst = 1'b1;
        do_sample(2'd1, 4'd9, 4'd9, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_channel_scheduler.md
IIR_CHANNEL_SCHEDULER -- requirements
Module: iir_channel_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of requester channels; fixed at 4 in this release.
REQ-002 Parameter W, default 4: sample, coefficient and output width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NCH  per-channel sample request.
REQ-006 req_x  input  NCH*W  per-channel sample x; channel i occupies bits [i*W +: W].
REQ-007 req_ready  output  NCH  one-hot, one-cycle acceptance pulse.
REQ-008 cfg_we  input  1  coefficient write strobe.
REQ-009 cfg_ch  input  2  channel addressed by cfg_we.
REQ-010 cfg_a  input  W  new feedback coefficient a.
REQ-011 out_valid  output  1  one-cycle result strobe; no backpressure.
REQ-012 out_ch  output  2  channel of the current result.
REQ-013 out_y  output  W  filter output y.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL time-share one first-order IIR engine among NCH channels, each with private registers a[i] and y_prev[i].
REQ-016 Per sample, the engine SHALL compute y = (x + a*y_prev) modulo 2^W: full 2W-bit product, sum truncated to W bits, no saturation.
REQ-017 FSM states SHALL be IDLE, GRANT, CALC and EMIT.
REQ-018 IDLE -> GRANT when any req_valid bit is high; otherwise stay in IDLE.
REQ-019 In GRANT, the block SHALL:
- select the channel by round-robin, searching upward from (last granted + 1) mod NCH; after reset, last granted = NCH-1;
- latch ch, x, a[ch] and y_prev[ch];
- assert req_ready[ch] for that cycle only.
REQ-020 GRANT -> CALC unconditionally; the registered engine result is produced in CALC.
REQ-021 In EMIT, out_valid=1, out_ch=latched ch, out_y=result, and y_prev[ch]<=result.
REQ-022 EMIT -> GRANT if any req_valid is high, else EMIT -> IDLE.
REQ-023 Latency: out_valid SHALL rise exactly 2 cycles after the req_ready pulse. Peak throughput is one sample per 3 cycles.
REQ-024 A request without an accompanying req_ready pulse is not consumed; the requester holds req_valid and req_x until it sees req_ready.
REQ-025 cfg_we SHALL set a[cfg_ch]<=cfg_a and y_prev[cfg_ch]<=0 in the same cycle, in any FSM state.
REQ-026 A sample already latched in GRANT uses its latched a and y_prev, regardless of later cfg_we.
REQ-027 If cfg_we targets ch during EMIT for that same ch, the cfg clear wins: y_prev[ch]=0. out_y is still emitted with the computed value.
REQ-028 out_ch and out_y SHALL hold their last values when out_valid=0.
REQ-029 Channels whose req_valid is low are skipped by round-robin without consuming cycles.

Reset
REQ-030 While rst=0: FSM=IDLE, req_ready=0, out_valid=0, out_ch=0, out_y=0, busy=0, all a[i]=0, all y_prev[i]=0, last granted=NCH-1.
REQ-031 Reset asserted mid-operation SHALL abandon the in-flight sample with no out_valid. Operation resumes from IDLE on the first edge after release.

Structure
REQ-032 A shared package SHALL hold W, NCH, the FSM state enum, and the channel-index width (clog2 NCH).
REQ-033 The engine SHALL be a sub-module iir_mac_engine (inputs x, a, y_prev; output y registered in CALC). The scheduler holds the FSM, arbiter and per-channel register files.

Verification
REQ-034 After reset, cfg ch0 a=2, then ch0 requests x=1 twice -> out_y=1 (ch0), then out_y=3 (ch0); out_valid exactly 2 cycles after each req_ready.
REQ-035 cfg ch1 a=3; force y_prev=5 via a prior x=5 sample; then x=2 -> out_y=1 (17 mod 16).
REQ-036 All four req_valid held high -> grant order 0,1,2,3,0, one grant every 3 cycles, req_ready always one-hot.
REQ-037 cfg_we to ch2 during ch2's EMIT -> out_y emitted unchanged; next ch2 sample with x=4 -> out_y=4.
REQ-038 rst pulled low during CALC -> no out_valid; all outputs 0; after release, a fresh request completes with y_prev=0 and a=0, so out_y=x.
REQ-039 Only ch3 requesting after a ch1 grant -> ch3 is granted in the next GRANT, without idle cycles spent on ch2.
